// File: rtl/i2_router_pkg.sv
// rtl/i2_router_pkg.sv - shared flit type definitions for the router input FIFO.
package i2_router_pkg;

    localparam int FLIT_TYPE_W = 3;

    typedef logic [FLIT_TYPE_W-1:0] flit_type_t;

    localparam flit_type_t FLIT_HEAD = 3'b001;
    localparam flit_type_t FLIT_TAIL = 3'b110;

endpackage : i2_router_pkg

// File: rtl/i2_router_fifo_mem.sv
// rtl/i2_router_fifo_mem.sv - DEPTH x WIDTH flit storage, one write port, one async read port.
module i2_router_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    // Contents are deliberately left unreset; only the pointers define validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : i2_router_fifo_mem

// File: rtl/i2_router_flit_fifo.sv
// rtl/i2_router_flit_fifo.sv - two-source router flit FIFO; I2_FIFO_OVF_CHK_EN adds sticky ovf_err.
module i2_router_flit_fifo
    import i2_router_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_TYPE_W-1:0] head1,
    input  logic [DATA_W-1:0]      data1,
    input  logic [FLIT_TYPE_W-1:0] head2,
    input  logic [DATA_W-1:0]      data2,
    input  logic                   select,
    input  logic                   FIFO_wr,
    output logic                   FIFO_full,
    output logic                   FIFO_empty,
    output logic                   out_req,
    output logic [FLIT_TYPE_W-1:0] out_head,
    output logic [DATA_W-1:0]      out_data,
`ifdef I2_FIFO_OVF_CHK_EN
    output logic                   ovf_err,
`endif
    input  logic                   out_bussy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + FLIT_TYPE_W;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_flit;
    logic [EW-1:0] rd_flit;

    // Status is decoded from the registered count only, so no input reaches it combinationally.
    assign FIFO_full  = (count_q == CW'(DEPTH));
    assign FIFO_empty = (count_q == '0);
    assign out_req    = ~FIFO_empty;

    assign push    = FIFO_wr & ~FIFO_full;
    assign pop     = out_req & ~out_bussy;
    assign wr_flit = select ? {head2, data2} : {head1, data1};

    assign {out_head, out_data} = rd_flit;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef I2_FIFO_OVF_CHK_EN
    logic ovf_err_q, ovf_err_d;

    assign ovf_err_d = ovf_err_q | (FIFO_wr & FIFO_full);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
`endif

    i2_router_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_flit),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_flit)
    );

endmodule : i2_router_flit_fifo

// File: tb/tb_i2_router_flit_fifo.sv
// tb/tb_i2_router_flit_fifo.sv - randomized self-checking bench for i2_router_flit_fifo.
module tb_i2_router_flit_fifo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int EW     = DATA_W + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [2:0]        head1 = '0, head2 = '0;
    logic [DATA_W-1:0] data1 = '0, data2 = '0;
    logic              select = 1'b0;
    logic              FIFO_wr = 1'b0;
    logic              FIFO_full, FIFO_empty, out_req;
    logic [2:0]        out_head;
    logic [DATA_W-1:0] out_data;
    logic              out_bussy = 1'b0;
`ifdef I2_FIFO_OVF_CHK_EN
    logic              ovf_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] model_q [$];
    logic          ovf_m = 1'b0;

    always #5 clk = ~clk;

    i2_router_flit_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .head1      (head1),
        .data1      (data1),
        .head2      (head2),
        .data2      (data2),
        .select     (select),
        .FIFO_wr    (FIFO_wr),
        .FIFO_full  (FIFO_full),
        .FIFO_empty (FIFO_empty),
        .out_req    (out_req),
        .out_head   (out_head),
        .out_data   (out_data),
`ifdef I2_FIFO_OVF_CHK_EN
        .ovf_err    (ovf_err),
`endif
        .out_bussy  (out_bussy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status();
        check("out_req", 64'(out_req), 64'(model_q.size() != 0));
        check("empty", 64'(FIFO_empty), 64'(model_q.size() == 0));
        check("full", 64'(FIFO_full), 64'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            check("head_flit", 64'({out_head, out_data}), 64'(model_q[0]));
        end
`ifdef I2_FIFO_OVF_CHK_EN
        check("ovf_err", 64'(ovf_err), 64'(ovf_m));
`endif
    endtask

    // One clock: drive at negedge, check, then apply the FIFO rules to the queue at the edge.
    task automatic cyc(input logic wr, input logic sel, input logic busy,
                       input logic [2:0] h, input logic [DATA_W-1:0] d);
        bit do_pop, do_push;
        FIFO_wr   = wr;
        select    = sel;
        out_bussy = busy;
        if (sel) begin
            head2 = h; data2 = d;
            head1 = 3'($urandom); data1 = $urandom;
        end else begin
            head1 = h; data1 = d;
            head2 = 3'($urandom); data2 = $urandom;
        end
        #1;
        check_status();
        @(posedge clk);
        do_pop  = (model_q.size() != 0) && !busy;
        do_push = wr && (model_q.size() < DEPTH);
        if (wr && model_q.size() == DEPTH) ovf_m = 1'b1;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back({h, d});
        @(negedge clk);
    endtask

    task automatic do_reset();
        FIFO_wr = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_out_req", 64'(out_req), 64'(0));
        check("rst_empty", 64'(FIFO_empty), 64'(1));
        check("rst_full", 64'(FIFO_full), 64'(0));
        model_q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("init_empty", 64'(FIFO_empty), 64'(1));
        check("init_out_req", 64'(out_req), 64'(0));
        rst = 1'b1;

        // Single flit, first edge after reset release, visible one cycle later.
        cyc(1, 0, 0, 3'b001, 32'hA5);
        check("lat_out_req", 64'(out_req), 64'(1));
        check("lat_head", 64'(out_head), 64'(3'b001));
        check("lat_data", 64'(out_data), 64'(32'hA5));
        cyc(0, 0, 0, 3'b000, 32'h0);
        cyc(0, 0, 0, 3'b000, 32'h0);

        // Fill while blocked, drop a fifth write, then drain.
        for (int i = 0; i < 4; i++) cyc(1, i[0], 1, 3'(i + 1), 32'h100 + 32'(i));
        cyc(1, 0, 1, 3'b111, 32'hDEAD);
        check("fill_full", 64'(FIFO_full), 64'(1));
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 3'b000, 32'h0);
`ifdef I2_FIFO_OVF_CHK_EN
        check("ovf_sticky", 64'(ovf_err), 64'(1));
        do_reset();
`endif

        // Full with simultaneous write and read: only the read happens.
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 3'b110, 32'h200 + 32'(i));
        cyc(1, 0, 0, 3'b001, 32'hBEEF);
        check("fr_not_full", 64'(FIFO_full), 64'(0));
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 3'b000, 32'h0);
`ifdef I2_FIFO_OVF_CHK_EN
        do_reset();
`endif

        // Streaming with continuous reads across pointer wrap.
        for (int i = 0; i < 10; i++) cyc(1, i[0], 0, 3'(i), 32'h300 + 32'(i));
        cyc(0, 0, 0, 3'b000, 32'h0);
        check("stream_empty", 64'(FIFO_empty), 64'(1));

        // Async reset with two flits stored.
        cyc(1, 0, 1, 3'b001, 32'h400);
        cyc(1, 1, 1, 3'b010, 32'h401);
        check("pre_rst_req", 64'(out_req), 64'(1));
        do_reset();
        cyc(0, 0, 0, 3'b000, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                3'($urandom), $urandom);
            if (i == 200) do_reset();
        end
        cyc(0, 0, 0, 3'b000, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_i2_router_flit_fifo
